// File: rtl/wakeup_issue_queue.sv
// rtl/wakeup_issue_queue.sv - dual-dispatch reservation station with tag wakeup and age-matrix select
// Purpose: holds renamed ops until both sources are ready, tracks readiness from
//          tag broadcasts and issues the oldest ready op through a valid/ready handshake.
// Ports:   clk, rst (sync, active-high), flush (drop everything)
//          disp_valid/payload/rob_id/src1_tag/src2_tag/src1_rdy/src2_rdy : dispatch slots, slot 0 older
//          disp_ready     : registered free count covers a full dispatch group
//          wakeup_valid/wakeup_tag : physical tag broadcasts
//          issue_valid/issue_ready/issue_payload/issue_rob_id : issue handshake
//          free_count     : registered number of free entries
module wakeup_issue_queue #(
   parameter int NUM_ENTRIES = 8,
   parameter int DISPATCH_W  = 2,
   parameter int NUM_WAKEUP  = 2,
   parameter int PHY_REGS    = 64,
   parameter int ROB_WIDTH   = 4,
   parameter int PAYLOAD_W   = 64,
   parameter int TAG_W       = $clog2(PHY_REGS),
   parameter int CNT_W       = $clog2(NUM_ENTRIES) + 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          flush,
   input  logic [DISPATCH_W-1:0]         disp_valid,
   input  logic [DISPATCH_W*PAYLOAD_W-1:0] disp_payload,
   input  logic [DISPATCH_W*ROB_WIDTH-1:0] disp_rob_id,
   input  logic [DISPATCH_W*TAG_W-1:0]   disp_src1_tag,
   input  logic [DISPATCH_W*TAG_W-1:0]   disp_src2_tag,
   input  logic [DISPATCH_W-1:0]         disp_src1_rdy,
   input  logic [DISPATCH_W-1:0]         disp_src2_rdy,
   output logic                          disp_ready,
   input  logic [NUM_WAKEUP-1:0]         wakeup_valid,
   input  logic [NUM_WAKEUP*TAG_W-1:0]   wakeup_tag,
   output logic                          issue_valid,
   input  logic                          issue_ready,
   output logic [PAYLOAD_W-1:0]          issue_payload,
   output logic [ROB_WIDTH-1:0]          issue_rob_id,
   output logic [CNT_W-1:0]              free_count
);
   localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

   logic [NUM_ENTRIES-1:0] valid, src1_rdy, src2_rdy, ready, sel;
   logic [PAYLOAD_W-1:0]   payload  [NUM_ENTRIES];
   logic [ROB_WIDTH-1:0]   rob_id   [NUM_ENTRIES];
   logic [TAG_W-1:0]       src1_tag [NUM_ENTRIES];
   logic [TAG_W-1:0]       src2_tag [NUM_ENTRIES];
   logic [NUM_ENTRIES-1:0] older    [NUM_ENTRIES];   // older[i][j]: entry i is older than entry j
   logic [CNT_W-1:0]       free_cnt, n_disp;
   logic [DISPATCH_W-1:0]  slot_en;
   logic [IDX_W-1:0]       slot_idx [DISPATCH_W];
   logic [IDX_W-1:0]       sel_idx;
   logic                   disp_ok, issue_fire;

   function automatic logic tag_woken(input logic [TAG_W-1:0] tag,
                                      input logic [NUM_WAKEUP-1:0] wv,
                                      input logic [NUM_WAKEUP*TAG_W-1:0] wt);
      logic hit;
      hit = 1'b0;
      for (int p = 0; p < NUM_WAKEUP; p++)
         if (wv[p] && wt[p*TAG_W +: TAG_W] == tag) hit = 1'b1;
      return hit;
   endfunction

   assign free_count = free_cnt;
   assign disp_ready = free_cnt >= CNT_W'(DISPATCH_W);
   assign disp_ok    = disp_ready & ~flush & ~rst;

   // Lowest free index per slot in slot order. An entry issuing this cycle still
   // has its valid bit set, so it cannot be reallocated until the next cycle.
   always_comb begin
      logic [NUM_ENTRIES-1:0] taken;
      taken  = valid;
      n_disp = '0;
      for (int s = 0; s < DISPATCH_W; s++) begin
         slot_en[s]  = 1'b0;
         slot_idx[s] = '0;
         if (disp_valid[s] && disp_ok) begin
            for (int i = NUM_ENTRIES - 1; i >= 0; i--)
               if (!taken[i]) begin
                  slot_en[s]  = 1'b1;
                  slot_idx[s] = IDX_W'(i);
               end
            if (slot_en[s]) begin
               taken[slot_idx[s]] = 1'b1;
               n_disp = n_disp + 1'b1;
            end
         end
      end
   end

   // Oldest-ready select: an entry wins unless some other ready entry is older.
   always_comb begin
      for (int i = 0; i < NUM_ENTRIES; i++)
         ready[i] = valid[i] & src1_rdy[i] & src2_rdy[i];
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         sel[i] = ready[i];
         for (int j = 0; j < NUM_ENTRIES; j++)
            if (ready[j] && older[j][i]) sel[i] = 1'b0;
      end
   end

   always_comb begin
      issue_payload = '0;
      issue_rob_id  = '0;
      sel_idx       = '0;
      for (int i = 0; i < NUM_ENTRIES; i++)
         if (sel[i]) begin
            issue_payload = payload[i];
            issue_rob_id  = rob_id[i];
            sel_idx       = IDX_W'(i);
         end
   end

   assign issue_valid = (|ready) & ~flush;
   assign issue_fire  = issue_valid & issue_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid    <= '0;
         free_cnt <= CNT_W'(NUM_ENTRIES);
         for (int i = 0; i < NUM_ENTRIES; i++) older[i] <= '0;
      end else if (flush) begin
         valid    <= '0;
         free_cnt <= CNT_W'(NUM_ENTRIES);
      end else begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (!src1_rdy[i] && tag_woken(src1_tag[i], wakeup_valid, wakeup_tag)) src1_rdy[i] <= 1'b1;
            if (!src2_rdy[i] && tag_woken(src2_tag[i], wakeup_valid, wakeup_tag)) src2_rdy[i] <= 1'b1;
         end
         if (issue_fire) valid[sel_idx] <= 1'b0;
         for (int s = 0; s < DISPATCH_W; s++)
            if (slot_en[s]) begin
               valid[slot_idx[s]]    <= 1'b1;
               payload[slot_idx[s]]  <= disp_payload[s*PAYLOAD_W +: PAYLOAD_W];
               rob_id[slot_idx[s]]   <= disp_rob_id[s*ROB_WIDTH +: ROB_WIDTH];
               src1_tag[slot_idx[s]] <= disp_src1_tag[s*TAG_W +: TAG_W];
               src2_tag[slot_idx[s]] <= disp_src2_tag[s*TAG_W +: TAG_W];
               src1_rdy[slot_idx[s]] <= disp_src1_rdy[s] |
                                        tag_woken(disp_src1_tag[s*TAG_W +: TAG_W], wakeup_valid, wakeup_tag);
               src2_rdy[slot_idx[s]] <= disp_src2_rdy[s] |
                                        tag_woken(disp_src2_tag[s*TAG_W +: TAG_W], wakeup_valid, wakeup_tag);
               older[slot_idx[s]]    <= '0;
            end
         // Column writes come after the row clears so the slot-0 -> slot-1 bit survives.
         for (int s = 0; s < DISPATCH_W; s++)
            if (slot_en[s])
               for (int j = 0; j < NUM_ENTRIES; j++) begin
                  older[j][slot_idx[s]] <= valid[j];
                  for (int t = 0; t < s; t++)
                     if (slot_en[t] && slot_idx[t] == IDX_W'(j)) older[j][slot_idx[s]] <= 1'b1;
               end
         free_cnt <= free_cnt - n_disp + CNT_W'(issue_fire);
      end
   end

   a_disp_when_full: assert property (@(posedge clk) disable iff (rst)
      !((|disp_valid) && !disp_ready && !flush));
endmodule
